bb84_sift_packer: RTL and testbench

BB84_SIFT_PACKER -- requirements
Module: bb84_sift_packer

---
 rtl/bb84_sift_packer.sv | 168 ++++++++++++++++
 tb/tb_bb84_sift_packer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bb84_sift_packer.sv
// bb84_sift_packer: sifts a BB84 frame LANES qubits per clock and packs the key bits into OUT_W-bit words.
module bb84_sift_packer #(
  parameter int N     = 80,
  parameter int LANES = 8,
  parameter int OUT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*N-1:0]               qubit,
  input  logic [N-1:0]                 sender_bases,
  input  logic [N-1:0]                 receiver_bases,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [$clog2(OUT_W+1)-1:0]   out_count,
  output logic                         out_last,
  output logic [$clog2(N+1)-1:0]       sift_count,
  output logic [$clog2(N+1)-1:0]       enc_err_count,
  output logic                         done
);
  localparam int G   = N / LANES;
  localparam int GW  = $clog2(G + 1);
  localparam int CW  = $clog2(N + 1);
  localparam int OCW = $clog2(OUT_W + 1);
  localparam int AW  = OUT_W + LANES;
  localparam int ANW = $clog2(AW + 1);
  localparam int LW  = $clog2(LANES + 1);
  typedef enum logic [1:0] {IDLE, SIFT, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] qb_q, qb_d;
  logic [N-1:0] sb_q, sb_d, rb_q, rb_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [ANW-1:0] an_q, an_d;
  logic ov_q, ov_d, ol_q, ol_d, ll_q, ll_d;
  logic [OUT_W-1:0] od_q, od_d;
  logic [OCW-1:0] oc_q, oc_d;
  logic [CW-1:0] sc_q, sc_d, ec_q, ec_d;
  logic [N-1:0] sm, em;
  logic [LANES-1:0] gs, ge, gk, comp;
  logic [LW-1:0] ns, ne;
  logic rest, full, slot, emit, full_last;
  // rest flags sifted bits still ahead, so a full word can be marked last when nothing follows it
  always_comb begin
    sm = '0;
    em = '0;
    gs = '0;
    ge = '0;
    gk = '0;
    rest = 1'b0;
    comp = '0;
    ns = '0;
    ne = '0;
    for (int i = 0; i < N; i++) begin
      sm[i] = (sb_q[i] == rb_q[i]) && (qb_q[2*i+1] == sb_q[i]);
      em[i] = (sb_q[i] == rb_q[i]) && (qb_q[2*i+1] != sb_q[i]);
    end
    for (int j = 0; j < G; j++) begin
      if (GW'(j) == grp_q) begin
        gs = sm[j*LANES +: LANES];
        ge = em[j*LANES +: LANES];
        for (int k = 0; k < LANES; k++) gk[k] = qb_q[2*(j*LANES+k)];
      end
      if (GW'(j) >= grp_q) rest = rest | (|sm[j*LANES +: LANES]);
    end
    for (int k = 0; k < LANES; k++) begin
      if (gs[k]) begin
        comp = comp | (LANES'(gk[k]) << ns);
        ns = ns + LW'(1);
      end
      ne = ne + LW'(ge[k]);
    end
  end
  assign full      = an_q >= ANW'(OUT_W);
  assign slot      = !ov_q || out_ready;
  assign full_last = (an_q == ANW'(OUT_W)) && !rest;
  assign emit      = (state_q == SIFT || state_q == FLUSH) && !ll_q && slot && (full || state_q == FLUSH);
  always_comb begin
    state_d = state_q;
    qb_d = qb_q;
    sb_d = sb_q;
    rb_d = rb_q;
    grp_d = grp_q;
    acc_d = acc_q;
    an_d = an_q;
    ov_d = (ov_q && out_ready) ? 1'b0 : ov_q;
    od_d = od_q;
    oc_d = oc_q;
    ol_d = ol_q;
    ll_d = ll_q;
    sc_d = sc_q;
    ec_d = ec_q;
    if (state_q == IDLE && in_valid) begin
      qb_d = qubit;
      sb_d = sender_bases;
      rb_d = receiver_bases;
      grp_d = '0;
      acc_d = '0;
      an_d = '0;
      sc_d = '0;
      ec_d = '0;
      ll_d = 1'b0;
      state_d = SIFT;
    end else if (emit) begin
      ov_d = 1'b1;
      od_d = acc_q[OUT_W-1:0];
      oc_d = full ? OCW'(OUT_W) : OCW'(an_q);
      ol_d = full ? full_last : 1'b1;
      ll_d = full ? full_last : 1'b1;
      acc_d = full ? acc_q >> OUT_W : '0;
      an_d = full ? an_q - ANW'(OUT_W) : '0;
    end else if (state_q == SIFT && !full) begin
      acc_d = acc_q | (AW'(comp) << an_q);
      an_d = an_q + ANW'(ns);
      sc_d = sc_q + CW'(ns);
      ec_d = ec_q + CW'(ne);
      grp_d = grp_q + GW'(1);
      state_d = (grp_q == GW'(G - 1)) ? FLUSH : SIFT;
    end else if (state_q == FLUSH && ll_q && slot) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      qb_q <= '0;
      sb_q <= '0;
      rb_q <= '0;
      grp_q <= '0;
      acc_q <= '0;
      an_q <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
      oc_q <= '0;
      ol_q <= 1'b0;
      ll_q <= 1'b0;
      sc_q <= '0;
      ec_q <= '0;
    end else begin
      state_q <= state_d;
      qb_q <= qb_d;
      sb_q <= sb_d;
      rb_q <= rb_d;
      grp_q <= grp_d;
      acc_q <= acc_d;
      an_q <= an_d;
      ov_q <= ov_d;
      od_q <= od_d;
      oc_q <= oc_d;
      ol_q <= ol_d;
      ll_q <= ll_d;
      sc_q <= sc_d;
      ec_q <= ec_d;
    end
  end
  assign in_ready      = state_q == IDLE;
  assign done          = state_q == DONE;
  assign out_valid     = ov_q;
  assign out_data      = od_q;
  assign out_count     = oc_q;
  assign out_last      = ol_q;
  assign sift_count    = sc_q;
  assign enc_err_count = ec_q;
endmodule

// File: tb/tb_bb84_sift_packer.sv
// tb_bb84_sift_packer: directed frames; a scoreboard queue of expected words is checked by a monitor.
module tb_bb84_sift_packer;
  localparam int N = 80;
  localparam int L = 8;
  localparam int W = 16;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [2*N-1:0] qubit = '0;
  logic [N-1:0] sb = '0, rb = '0;
  logic in_ready, out_valid, out_last, done;
  logic [W-1:0] out_data;
  logic [4:0] out_count;
  logic [6:0] sift_count, enc_err_count;
  bb84_sift_packer #(.N(N), .LANES(L), .OUT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .qubit(qubit),
    .sender_bases(sb), .receiver_bases(rb), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_last(out_last), .sift_count(sift_count),
    .enc_err_count(enc_err_count), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [W-1:0] d; logic [4:0] c; logic l;} word_t;
  word_t sbq[$];
  int checks = 0, failures = 0, done_cnt = 0;
  bit mon_en = 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [W-1:0] d, input logic [4:0] c, input logic l);
    word_t w;
    w.d = d;
    w.c = c;
    w.l = l;
    sbq.push_back(w);
  endtask
  // every cycle a word is presented it must match the head of the queue, so a stalled word must hold
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (sbq.size() == 0) chk("unexpected_word", {16'h0, out_data}, 32'hFFFF_FFFF);
        else begin
          chk("out_data", out_data, sbq[0].d);
          chk("out_count", out_count, sbq[0].c);
          chk("out_last", out_last, sbq[0].l);
          if (out_ready) void'(sbq.pop_front());
        end
      end
    end
  end
  task automatic frame(input logic [2*N-1:0] q, input logic [N-1:0] s, input logic [N-1:0] r,
                       input int es, input int ee, input int stall_at);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    chk("in_ready_idle", in_ready, 1);
    qubit = q;
    sb = s;
    rb = r;
    in_valid = 1;
    done_cnt = 0;
    @(posedge clk); #1;
    in_valid = 0;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 300) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && cyc == stall_at) out_ready = 0;
      if (stall_at >= 0 && cyc == stall_at + 20) out_ready = 1;
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
      else if (in_ready) chk("in_ready_busy", in_ready, 0);
    end
    chk("done_seen", seen, 1);
    if (stall_at < 0) chk("latency_bound", cyc <= N/L + (N+W-1)/W + 3, 1);
    chk("sift_count", sift_count, es);
    chk("enc_err_count", enc_err_count, ee);
    chk("queue_drained", sbq.size(), 0);
    @(negedge clk);
    chk("done_pulse_once", done_cnt, 1);
    chk("done_low", done, 0);
    chk("in_ready_back", in_ready, 1);
    chk("sift_hold", sift_count, es);
    chk("err_hold", enc_err_count, ee);
  endtask
  logic [2*N-1:0] q1, q3, q4;
  logic [N-1:0] r3, s4;
  initial begin
    for (int i = 0; i < N; i++) begin
      q1[2*i] = i[0];
      q1[2*i+1] = 1'b0;
      q3[2*i] = 1'b1;
      q3[2*i+1] = 1'b0;
      r3[i] = i[0];
      s4[i] = (i % 8 == 0);
      q4[2*i] = (i % 8 != 0);
      q4[2*i+1] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_counts", {sift_count, enc_err_count, out_count}, 0);
    chk("rst_last_done", {out_last, done}, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    for (int k = 0; k < 5; k++) push(16'hAAAA, 16, k == 4);
    frame(q1, '0, '0, 80, 0, -1);
    push(16'h0000, 0, 1);
    frame(q1, '0, '1, 0, 0, -1);
    push(16'hFFFF, 16, 0);
    push(16'hFFFF, 16, 0);
    push(16'h00FF, 8, 1);
    frame(q3, '0, r3, 40, 0, -1);
    for (int k = 0; k < 4; k++) push(16'hFFFF, 16, 0);
    push(16'h003F, 6, 1);
    frame(q4, s4, s4, 70, 10, -1);
    for (int k = 0; k < 5; k++) push(16'hAAAA, 16, k == 4);
    frame(q1, '0, '0, 80, 0, 3);
    mon_en = 0;
    @(posedge clk); #1;
    qubit = q1;
    sb = '0;
    rb = '0;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    out_ready = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_word_pending", out_valid, 1);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", {out_data, out_count, out_last}, 0);
    chk("midrst_counts", {sift_count, enc_err_count, done}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    mon_en = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_no_word", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);
    end
    for (int k = 0; k < 5; k++) push(16'hAAAA, 16, k == 4);
    frame(q1, '0, '0, 80, 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
